lcd_char_sequencer: RTL and testbench



---
 rtl/lcd_char_sequencer_pkg.sv | 50 +++++
 rtl/lcd_char_sequencer_if.sv | 12 +
 rtl/lcd_char_sequencer_wait_timer.sv | 28 ++
 rtl/lcd_char_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_lcd_char_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_char_sequencer_pkg.sv
// Shared types and constants for the HD44780 character sequencer:
// FSM states, wait selectors, the power-up init ROM and command bytes.
package lcd_char_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      LOAD,
      SETUP,
      PULSE,
      HOLD,
      WAIT,
      IDLE
   } state_t;

   typedef enum logic [1:0] {
      WS_INIT1,
      WS_INIT2,
      WS_CMD,
      WS_CLEAR
   } wait_sel_t;

   typedef struct packed {
      logic [7:0] data;
      wait_sel_t  wsel;
   } init_entry_t;

   localparam int INIT_LEN = 8;

   // 8-bit bus, 2 lines, display off, clear, entry increment, display on
   localparam init_entry_t INIT_ROM [INIT_LEN] = '{
      '{8'h38, WS_INIT1},
      '{8'h38, WS_INIT2},
      '{8'h38, WS_CMD},
      '{8'h38, WS_CMD},
      '{8'h08, WS_CMD},
      '{8'h01, WS_CLEAR},
      '{8'h06, WS_CMD},
      '{8'h0C, WS_CMD}
   };

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] ROW1_BASE     = 8'h40;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_char_sequencer_if.sv
// Client write port of the LCD sequencer.
// A byte moves on a clock edge where wr_valid and wr_ready are both 1; the
// master holds wr_is_cmd/wr_data stable while wr_valid is 1 and not yet accepted.
interface lcd_char_sequencer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic       wr_is_cmd;
   logic [7:0] wr_data;

   modport master (output wr_valid, output wr_is_cmd, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_is_cmd, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_char_sequencer_wait_timer.sv
// Loadable down-counter shared by every timed FSM state; o_done is high
// while the count sits at zero, so a load of N-1 gives an N-cycle state.
module lcd_wait_timer #(
   parameter int W       = 8,
   parameter int RST_VAL = 0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= W'(RST_VAL);
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_char_sequencer.sv
// HD44780 8-bit write-only sequencer: power-up wait, init ROM, then client
// bytes with RS/DATA setup, EN pulse, hold, execution wait and cursor tracking.
module lcd_char_sequencer
   import lcd_char_pkg::*;
#(
   parameter int CLK_HZ         = 50000000,
   parameter int POWERUP_US     = 15000,
   parameter int INIT_WAIT1_US  = 4100,
   parameter int INIT_WAIT2_US  = 100,
   parameter int CMD_WAIT_US    = 40,
   parameter int CLEAR_WAIT_US  = 1640,
   parameter int SETUP_CYCLES   = 2,
   parameter int EN_HIGH_CYCLES = 12,
   parameter int HOLD_CYCLES    = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   lcd_char_sequencer_if.slave        wr,
   input  logic                       backlight_en,
   output logic                       init_done,
   output logic                       cursor_row,
   output logic [3:0]                 cursor_col,
   output logic [7:0]                 LCD_DATA,
   output logic                       LCD_RS,
   output logic                       LCD_RW,
   output logic                       LCD_EN,
   output logic                       LCD_ON,
   output logic                       LCD_BLON,
   output state_t                     dbg_state
);

   localparam int US_CYC    = CLK_HZ / 1000000;
   localparam int PWRUP_CYC = POWERUP_US * US_CYC;
   localparam int INIT1_CYC = INIT_WAIT1_US * US_CYC;
   localparam int INIT2_CYC = INIT_WAIT2_US * US_CYC;
   localparam int CMD_CYC   = CMD_WAIT_US * US_CYC;
   localparam int CLEAR_CYC = CLEAR_WAIT_US * US_CYC;
   localparam int MAX_CYC   = max_int(max_int(max_int(PWRUP_CYC, INIT1_CYC),
                                              max_int(INIT2_CYC, CMD_CYC)),
                                      max_int(max_int(CLEAR_CYC, SETUP_CYCLES),
                                              max_int(EN_HIGH_CYCLES, HOLD_CYCLES)));
   localparam int TW        = $clog2(MAX_CYC + 1);

   state_t      r_state, w_next;
   logic        w_load, w_done, w_accept, w_last_init;
   logic [TW-1:0] w_load_val;
   logic [2:0]  r_idx, w_idx_nxt;
   logic [7:0]  r_data, w_row_cmd;
   wait_sel_t   r_wsel;
   logic        r_rs, r_en, r_on, r_blon, r_pend, r_init_done, r_row;
   logic [3:0]  r_col;

   function automatic logic [TW-1:0] wait_load(input wait_sel_t s);
      case (s)
         WS_INIT1: return TW'(INIT1_CYC - 1);
         WS_INIT2: return TW'(INIT2_CYC - 1);
         WS_CLEAR: return TW'(CLEAR_CYC - 1);
         default:  return TW'(CMD_CYC - 1);
      endcase
   endfunction

   lcd_wait_timer #(.W(TW), .RST_VAL(PWRUP_CYC - 1)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_done     (w_done)
   );

   assign wr.wr_ready = (r_state == IDLE) & ~r_pend;
   assign w_accept    = wr.wr_valid & wr.wr_ready;
   assign w_last_init = (r_idx == 3'(INIT_LEN - 1));
   assign w_idx_nxt   = r_idx + 3'd1;
   // Set-DDRAM command for column 0 of the other row (wrap and newline)
   assign w_row_cmd   = CMD_SET_DDRAM | (r_row ? 8'h00 : ROW1_BASE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= PWRUP;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         PWRUP: if (w_done) w_next = LOAD;
         LOAD: begin
            w_next     = SETUP;
            w_load     = 1'b1;
            w_load_val = TW'(SETUP_CYCLES - 1);
         end
         SETUP: if (w_done) begin
            w_next     = PULSE;
            w_load     = 1'b1;
            w_load_val = TW'(EN_HIGH_CYCLES - 1);
         end
         PULSE: if (w_done) begin
            w_next     = HOLD;
            w_load     = 1'b1;
            w_load_val = TW'(HOLD_CYCLES - 1);
         end
         HOLD: if (w_done) begin
            w_next     = WAIT;
            w_load     = 1'b1;
            w_load_val = wait_load(r_wsel);
         end
         WAIT: if (w_done) begin
            if (!r_init_done) w_next = w_last_init ? IDLE : LOAD;
            else              w_next = r_pend ? LOAD : IDLE;
         end
         IDLE: if (w_accept) w_next = LOAD;
         default: w_next = PWRUP;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_on        <= 1'b0;
         r_blon      <= 1'b0;
         r_en        <= 1'b0;
         r_rs        <= 1'b0;
         r_data      <= 8'h00;
         r_idx       <= 3'd0;
         r_wsel      <= WS_INIT1;
         r_pend      <= 1'b0;
         r_init_done <= 1'b0;
         r_row       <= 1'b0;
         r_col       <= 4'd0;
      end else begin
         r_on   <= 1'b1;
         r_blon <= backlight_en & r_on;
         r_en   <= (w_next == PULSE);
         case (r_state)
            PWRUP: if (w_done) begin
               r_idx  <= 3'd0;
               r_rs   <= 1'b0;
               r_data <= INIT_ROM[0].data;
               r_wsel <= INIT_ROM[0].wsel;
            end
            IDLE: if (w_accept) begin
               if (!wr.wr_is_cmd && wr.wr_data == 8'h0A) begin
                  r_rs   <= 1'b0;
                  r_data <= w_row_cmd;
                  r_wsel <= WS_CMD;
               end else begin
                  r_rs   <= ~wr.wr_is_cmd;
                  r_data <= wr.wr_data;
                  r_wsel <= (wr.wr_is_cmd && (wr.wr_data == CMD_CLEAR || wr.wr_data == CMD_HOME))
                            ? WS_CLEAR : WS_CMD;
               end
            end
            HOLD: if (w_done) begin
               if (r_rs) begin
                  r_col <= r_col + 4'd1;
                  if (r_col == 4'd15) r_pend <= 1'b1;
               end else if (r_data == CMD_CLEAR || r_data == CMD_HOME) begin
                  r_row <= 1'b0;
                  r_col <= 4'd0;
               end else if (r_data[7]) begin
                  r_row <= r_data[6];
                  r_col <= r_data[3:0];
               end
            end
            WAIT: if (w_done) begin
               if (!r_init_done) begin
                  if (w_last_init) begin
                     r_init_done <= 1'b1;
                     r_row       <= 1'b0;
                     r_col       <= 4'd0;
                  end else begin
                     r_idx  <= w_idx_nxt;
                     r_data <= INIT_ROM[w_idx_nxt].data;
                     r_wsel <= INIT_ROM[w_idx_nxt].wsel;
                  end
               end else if (r_pend) begin
                  r_pend <= 1'b0;
                  r_rs   <= 1'b0;
                  r_data <= w_row_cmd;
                  r_wsel <= WS_CMD;
               end
            end
            default: ;
         endcase
      end
   end

   assign init_done  = r_init_done;
   assign cursor_row = r_row;
   assign cursor_col = r_col;
   assign LCD_DATA   = r_data;
   assign LCD_RS     = r_rs;
   assign LCD_RW     = 1'b0;
   assign LCD_EN     = r_en;
   assign LCD_ON     = r_on;
   assign LCD_BLON   = r_blon;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_lcd_char_sequencer.sv
// Directed-plus-random bench for lcd_char_sequencer: EN pulses are collected
// by a monitor and compared with bytes and timings predicted from the LCD rules.
module tb_lcd_char_sequencer;

   localparam int CLK_HZ = 1000000;
   localparam int US     = CLK_HZ / 1000000;
   localparam int PWR    = 20;
   localparam int W1     = 8;
   localparam int W2     = 4;
   localparam int WCMD   = 3;
   localparam int WCLR   = 10;
   localparam int SU     = 2;
   localparam int EH     = 3;
   localparam int HO     = 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       backlight_en = 1'b0;
   logic       init_done, cursor_row;
   logic [3:0] cursor_col;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
   lcd_char_pkg::state_t dbg_state;

   lcd_char_sequencer_if wr_if ();

   lcd_char_sequencer #(
      .CLK_HZ(CLK_HZ), .POWERUP_US(PWR), .INIT_WAIT1_US(W1), .INIT_WAIT2_US(W2),
      .CMD_WAIT_US(WCMD), .CLEAR_WAIT_US(WCLR), .SETUP_CYCLES(SU),
      .EN_HIGH_CYCLES(EH), .HOLD_CYCLES(HO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr           (wr_if),
      .backlight_en (backlight_en),
      .init_done    (init_done),
      .cursor_row   (cursor_row),
      .cursor_col   (cursor_col),
      .LCD_DATA     (lcd_data),
      .LCD_RS       (lcd_rs),
      .LCD_RW       (lcd_rw),
      .LCD_EN       (lcd_en),
      .LCD_ON       (lcd_on),
      .LCD_BLON     (lcd_blon),
      .dbg_state    (dbg_state)
   );

   typedef struct {
      logic        rs;
      logic [7:0]  data;
      int unsigned rise;
      int unsigned width;
      logic        stable;
   } pulse_t;

   int unsigned cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   pulse_t      obs_q[$];
   logic [8:0]  exp_q[$];
   logic        m_row;
   logic [3:0]  m_col;
   logic [7:0]  init_rom [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
   int          init_wait [8] = '{W1, W2, WCMD, WCMD, WCMD, WCLR, WCMD, WCMD};

   // clock / reset / cycle counter
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // monitor: one record per EN pulse, pins checked for stability to the hold phase
   initial begin
      logic        prev_en;
      pulse_t      cur;
      prev_en = 1'b0;
      cur = '{rs: 1'b0, data: 8'h00, rise: 0, width: 0, stable: 1'b1};
      forever begin
         @(negedge clk);
         if (lcd_en === 1'b1 && !prev_en) begin
            cur = '{rs: lcd_rs, data: lcd_data, rise: cyc, width: 1, stable: 1'b1};
         end else if (lcd_en === 1'b1) begin
            cur.width = cur.width + 1;
            if (lcd_rs !== cur.rs || lcd_data !== cur.data) cur.stable = 1'b0;
         end else if (prev_en) begin
            if (lcd_rs !== cur.rs || lcd_data !== cur.data) cur.stable = 1'b0;
            obs_q.push_back(cur);
         end
         prev_en = (lcd_en === 1'b1);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d, required finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int xfer_cycles(input logic rs, input logic [7:0] b);
      int w;
      w = (!rs && (b == 8'h01 || b == 8'h02)) ? WCLR : WCMD;
      return 1 + SU + EH + HO + w * US;
   endfunction

   // reference model: bus bytes a client write should produce, and the cursor after it
   task automatic model_apply(input logic is_cmd, input logic [7:0] d, output int lat);
      logic [7:0] b;
      lat = 0;
      if (!is_cmd && d == 8'h0A) begin
         b = m_row ? 8'h80 : 8'hC0;
         exp_q.push_back({1'b0, b});
         lat = xfer_cycles(1'b0, b);
         m_row = ~m_row;
         m_col = 4'd0;
      end else if (!is_cmd) begin
         exp_q.push_back({1'b1, d});
         lat = xfer_cycles(1'b1, d);
         if (m_col == 4'd15) begin
            b = m_row ? 8'h80 : 8'hC0;
            exp_q.push_back({1'b0, b});
            lat = lat + xfer_cycles(1'b0, b);
            m_row = ~m_row;
            m_col = 4'd0;
         end else begin
            m_col = m_col + 4'd1;
         end
      end else begin
         exp_q.push_back({1'b0, d});
         lat = xfer_cycles(1'b0, d);
         if (d == 8'h01 || d == 8'h02) begin
            m_row = 1'b0;
            m_col = 4'd0;
         end else if (d[7]) begin
            m_row = d[6];
            m_col = d[3:0];
         end
      end
   endtask

   task automatic compare_pulses();
      pulse_t     p;
      logic [8:0] e;
      chk("pulse_count", obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         p = obs_q.pop_front();
         e = exp_q.pop_front();
         chk("pulse_rs", p.rs, e[8]);
         chk("pulse_data", p.data, e[7:0]);
         chk("en_width", p.width, EH);
         chk("pins_stable", p.stable, 1);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   // driver: one client write, then latency, pulses and cursor against the model
   task automatic write_byte(input logic is_cmd, input logic [7:0] d);
      int          lat;
      int          n;
      int unsigned c;
      model_apply(is_cmd, d, lat);
      n = 0;
      @(negedge clk);
      while (wr_if.wr_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_write", wr_if.wr_ready, 1);
      wr_if.wr_valid  = 1'b1;
      wr_if.wr_is_cmd = is_cmd;
      wr_if.wr_data   = d;
      c = cyc;
      @(negedge clk);
      wr_if.wr_valid  = 1'b0;
      wr_if.wr_is_cmd = $urandom_range(0, 1);
      wr_if.wr_data   = 8'($urandom);
      chk("ready_drop", wr_if.wr_ready, 0);
      n = 0;
      while (wr_if.wr_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ready_return", wr_if.wr_ready, 1);
      chk("accept_to_ready", cyc - (c + 1), lat);
      compare_pulses();
      chk("cursor_row", cursor_row, m_row);
      chk("cursor_col", cursor_col, m_col);
   endtask

   task automatic check_init(input int unsigned t0);
      int          n;
      int unsigned exp_rise;
      int unsigned total;
      pulse_t      p;
      total = PWR * US;
      for (int i = 0; i < 8; i++) total = total + 1 + SU + EH + HO + init_wait[i] * US;
      n = 0;
      while (init_done !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("init_done_seen", init_done, 1);
      chk("init_done_time", cyc - t0, total);
      chk("init_pulse_count", obs_q.size(), 8);
      exp_rise = t0 + PWR * US + 1 + SU;
      for (int i = 0; i < 8; i++) begin
         if (obs_q.size() > 0) begin
            p = obs_q.pop_front();
            chk("init_rs", p.rs, 0);
            chk("init_data", p.data, init_rom[i]);
            chk("init_rise", p.rise, exp_rise);
            chk("init_en_width", p.width, EH);
         end
         exp_rise = exp_rise + EH + HO + init_wait[i] * US + 1 + SU;
      end
      obs_q.delete();
      exp_q.delete();
      chk("init_cursor_row", cursor_row, 0);
      chk("init_cursor_col", cursor_col, 0);
      chk("init_ready", wr_if.wr_ready, 1);
      m_row = 1'b0;
      m_col = 4'd0;
   endtask

   initial begin
      int unsigned t0;
      int          r;
      int          n;
      wr_if.wr_valid  = 1'b0;
      wr_if.wr_is_cmd = 1'b0;
      wr_if.wr_data   = 8'h00;
      backlight_en    = 1'b1;
      m_row = 1'b0;
      m_col = 4'd0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_en", lcd_en, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_data", lcd_data, 0);
      chk("rst_on", lcd_on, 0);
      chk("rst_blon", lcd_blon, 0);
      chk("rst_ready", wr_if.wr_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_row", cursor_row, 0);
      chk("rst_col", cursor_col, 0);

      // power-up and init sequence
      reset_n = 1'b1;
      t0 = cyc;
      obs_q.delete();
      @(negedge clk);
      chk("on_first_clk", lcd_on, 1);
      chk("blon_lags_on", lcd_blon, 0);
      @(negedge clk);
      chk("blon_follows", lcd_blon, 1);
      chk("ready_during_init", wr_if.wr_ready, 0);
      check_init(t0);
      chk("rw_after_init", lcd_rw, 0);
      backlight_en = 1'b0;
      @(negedge clk);
      chk("blon_off", lcd_blon, 0);

      // single character
      write_byte(1'b0, 8'h41);

      // home, then two full lines with wrap commands
      write_byte(1'b1, 8'h02);
      for (int i = 0; i < 32; i++) write_byte(1'b0, 8'($urandom_range(8'h20, 8'h7E)));

      // clear and set-DDRAM
      write_byte(1'b1, 8'h01);
      write_byte(1'b1, 8'hC5);

      // newline from (0,7)
      write_byte(1'b1, 8'h87);
      write_byte(1'b0, 8'h0A);

      // random mix
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6)       write_byte(1'b0, 8'($urandom_range(8'h20, 8'h7E)));
         else if (r == 6) write_byte(1'b0, 8'h0A);
         else if (r == 7) write_byte(1'b1, 8'h80 | 8'($urandom_range(0, 1) << 6) | 8'($urandom_range(0, 15)));
         else if (r == 8) write_byte(1'b1, ($urandom_range(0, 1) == 1) ? 8'h06 : 8'h0C);
         else             write_byte(1'b1, ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02);
      end

      // reset while EN is high
      @(negedge clk);
      chk("ready_before_abort", wr_if.wr_ready, 1);
      wr_if.wr_valid  = 1'b1;
      wr_if.wr_is_cmd = 1'b0;
      wr_if.wr_data   = 8'h55;
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
      n = 0;
      while (lcd_en !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("en_seen_before_abort", lcd_en, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_en_async", lcd_en, 0);
      chk("abort_init_done", init_done, 0);
      chk("abort_ready", wr_if.wr_ready, 0);
      chk("abort_on", lcd_on, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      t0 = cyc;
      obs_q.delete();
      exp_q.delete();
      @(negedge clk);
      chk("on_after_rereset", lcd_on, 1);
      chk("init_done_after_rereset", init_done, 0);
      check_init(t0);
      write_byte(1'b0, 8'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
